// File: rtl/disp_page_ctrl_if.sv
// Display page controller bus: source requests in, registered display value/marker out.
// master = source/requester side, slave = page controller.
interface disp_page_ctrl_if #(
    parameter int NSRC = 4,
    parameter int W    = 16
);
    localparam int PW = $clog2(NSRC);

    logic                adv_tick;
    logic [NSRC*W-1:0]   src_data;
    logic [NSRC-1:0]     src_valid;
    logic [NSRC-1:0]     src_alert;
    logic [W-1:0]        value_out;
    logic                blank;
    logic [PW-1:0]       page;
    logic                page_chg;

    modport master (
        output adv_tick, src_data, src_valid, src_alert,
        input  value_out, blank, page, page_chg
    );

    modport slave (
        input  adv_tick, src_data, src_valid, src_alert,
        output value_out, blank, page, page_chg
    );
endinterface

// File: rtl/disp_page_ctrl.sv
// Round-robin display page arbiter with preemptive alert windows.
// Optional dwell-based auto-scroll is built when DISP_AUTOSCROLL_EN is defined.
//
// state | meaning
// IDLE  | no valid source, display blanked, page holds
// SHOW  | showing src_data[page], rotating on advance
// ALERT | showing alerting source for ALERT_CYCLES, then returning to saved page
module disp_page_ctrl #(
    parameter int NSRC         = 4,
    parameter int W            = 16,
    parameter int ALERT_CYCLES = 50_000_000,
    parameter int AUTO_CYCLES  = 150_000_000
) (
    input  logic                  clk,
    input  logic                  clr,
    disp_page_ctrl_if.slave       bus
);
    localparam int PW = $clog2(NSRC);
    localparam int AW = $clog2(ALERT_CYCLES);

    if (NSRC < 2 || NSRC > 8) begin : g_bad_nsrc
        $error("disp_page_ctrl: NSRC must be in 2..8");
    end
    if (ALERT_CYCLES < 2) begin : g_bad_alert
        $error("disp_page_ctrl: ALERT_CYCLES must be >= 2");
    end
    if (AUTO_CYCLES < 2) begin : g_bad_auto
        $error("disp_page_ctrl: AUTO_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   page_d;
    logic [PW-1:0]   saved_q, saved_d;
    logic [PW-1:0]   asrc_q, asrc_d;
    logic [AW-1:0]   acnt_q, acnt_d;
    logic            alert_any, valid_any, auto_exp, adv_req;
    logic [PW-1:0]   alert_low, valid_low;

    function automatic logic [PW-1:0] lowest(input logic [NSRC-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) r = PW'(i);
        end
        return r;
    endfunction

    // First valid index strictly after p (wrapping); falls back to p itself.
    function automatic logic [PW-1:0] next_valid(input logic [PW-1:0] p,
                                                 input logic [NSRC-1:0] v);
        logic [PW-1:0] r;
        logic [PW-1:0] idx;
        r = p;
        for (int k = NSRC - 1; k >= 1; k--) begin
            idx = PW'((int'(p) + k) % NSRC);
            if (v[idx]) r = idx;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] sel_data(input logic [PW-1:0] idx,
                                              input logic [NSRC*W-1:0] d);
        return d[int'(idx)*W +: W];
    endfunction

    assign alert_any = |bus.src_alert;
    assign valid_any = |bus.src_valid;
    assign alert_low = lowest(bus.src_alert);
    assign valid_low = lowest(bus.src_valid);
    assign adv_req   = bus.adv_tick | auto_exp;

    always_comb begin
        state_d = state_q;
        page_d  = bus.page;
        saved_d = saved_q;
        asrc_d  = asrc_q;
        acnt_d  = acnt_q;
        case (state_q)
            IDLE: begin
                if (alert_any) begin
                    state_d = ALERT;
                    saved_d = bus.page;
                    asrc_d  = alert_low;
                    page_d  = alert_low;
                    acnt_d  = AW'(ALERT_CYCLES - 1);
                end else if (valid_any) begin
                    state_d = SHOW;
                    page_d  = valid_low;
                end
            end
            SHOW: begin
                if (alert_any) begin
                    state_d = ALERT;
                    saved_d = bus.page;
                    asrc_d  = alert_low;
                    page_d  = alert_low;
                    acnt_d  = AW'(ALERT_CYCLES - 1);
                end else if (!valid_any) begin
                    state_d = IDLE;
                end else if (adv_req || !bus.src_valid[bus.page]) begin
                    page_d = next_valid(bus.page, bus.src_valid);
                end
            end
            ALERT: begin
                if (alert_any && (alert_low < asrc_q)) begin
                    asrc_d = alert_low;
                    page_d = alert_low;
                    acnt_d = AW'(ALERT_CYCLES - 1);
                end else if (bus.adv_tick || (acnt_q == '0)) begin
                    // Abort or expiry both fall back to the page shown before the alert.
                    if (bus.src_valid[saved_q]) begin
                        state_d = SHOW;
                        page_d  = saved_q;
                    end else if (valid_any) begin
                        state_d = SHOW;
                        page_d  = next_valid(saved_q, bus.src_valid);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    acnt_d = acnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            saved_q       <= '0;
            asrc_q        <= '0;
            acnt_q        <= '0;
            bus.page      <= '0;
            bus.value_out <= '0;
            bus.blank     <= 1'b1;
            bus.page_chg  <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            asrc_q        <= asrc_d;
            acnt_q        <= acnt_d;
            bus.page      <= page_d;
            bus.value_out <= (state_d == IDLE) ? '0 : sel_data(page_d, bus.src_data);
            bus.blank     <= (state_d == IDLE);
            bus.page_chg  <= (page_d != bus.page);
        end
    end

`ifdef DISP_AUTOSCROLL_EN
    localparam int DW = $clog2(AUTO_CYCLES);

    logic [DW-1:0] dwell_q;
    logic          dwell_load;

    assign auto_exp   = (state_q == SHOW) && (dwell_q == '0);
    assign dwell_load = (state_d == SHOW) &&
                        ((state_q != SHOW) || (page_d != bus.page) || adv_req);

    always_ff @(posedge clk) begin
        if (clr) begin
            dwell_q <= '0;
        end else if (dwell_load) begin
            dwell_q <= DW'(AUTO_CYCLES - 1);
        end else if ((state_q == SHOW) && (state_d == SHOW) && (dwell_q != '0)) begin
            dwell_q <= dwell_q - 1'b1;
        end
    end
`else
    assign auto_exp = 1'b0;
`endif

endmodule

// File: tb/tb_disp_page_ctrl.sv
// Directed self-checking bench for disp_page_ctrl (NSRC=4, ALERT_CYCLES=4, AUTO_CYCLES=8).
module tb_disp_page_ctrl;
    localparam int NSRC = 4;
    localparam int W    = 16;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   chg_cnt;

    disp_page_ctrl_if #(.NSRC(NSRC), .W(W)) bus ();

    disp_page_ctrl #(
        .NSRC(NSRC), .W(W), .ALERT_CYCLES(4), .AUTO_CYCLES(8)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [NSRC*W-1:0] DATA0 = {16'h4003, 16'h3002, 16'h2001, 16'h1000};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pg(input string tag, input int pg, input bit chg);
        chk({tag, ".page"}, 32'(bus.page), 32'(pg));
        chk({tag, ".chg"},  32'(bus.page_chg), 32'(chg));
    endtask

    task automatic pulse_adv(input string tag, input int pg);
        bus.adv_tick = 1'b1;
        step();
        bus.adv_tick = 1'b0;
        chk_pg(tag, pg, 1'b1);
        step();
        chk_pg({tag, "_hold"}, pg, 1'b0);
    endtask

    initial begin
        bus.adv_tick  = 1'b0;
        bus.src_data  = DATA0;
        bus.src_valid = '0;
        bus.src_alert = '0;

        // reset / idle
        step();
        step();
        chk("rst.blank", 32'(bus.blank), 32'd1);
        chk("rst.value", 32'(bus.value_out), 32'd0);
        chk_pg("rst", 0, 1'b0);
        clr = 1'b0;
        bus.src_valid = 4'b0100;
        step();
        chk_pg("idle2show", 2, 1'b1);
        chk("idle2show.blank", 32'(bus.blank), 32'd0);
        chk("idle2show.value", 32'(bus.value_out), 32'h3002);

        // round robin with wrap (page 2 invalid -> 3, then to 0)
        bus.src_valid = 4'b1011;
        step();
        chk_pg("loss2", 3, 1'b1);
        pulse_adv("rr0", 0);
        pulse_adv("rr1", 1);
        pulse_adv("rr3", 3);
        pulse_adv("rr0b", 0);

        // live data tracking
        bus.src_data[15:0] = 16'hBEEF;
        step();
        chk("track.value", 32'(bus.value_out), 32'hBEEF);
        bus.src_data = DATA0;
        step();

        // valid loss
        pulse_adv("vl1", 1);
        pulse_adv("vl3", 3);
        bus.src_valid = 4'b0011;
        step();
        chk_pg("loss3", 0, 1'b1);
        chk("loss3.value", 32'(bus.value_out), 32'h1000);
        bus.src_valid = 4'b0000;
        step();
        chk("none.blank", 32'(bus.blank), 32'd1);
        chk("none.value", 32'(bus.value_out), 32'd0);
        chk_pg("none", 0, 1'b0);

        // single valid source: adv_tick does nothing
        bus.src_valid = 4'b0010;
        step();
        chk_pg("single", 1, 1'b1);
        bus.adv_tick = 1'b1;
        step();
        bus.adv_tick = 1'b0;
        chk_pg("single.adv", 1, 1'b0);

        // alert window of exactly 4 cycles
        bus.src_valid = 4'b0011;
        bus.src_alert = 4'b0100;
        step();
        bus.src_alert = '0;
        chk_pg("al.enter", 2, 1'b1);
        chk("al.value", 32'(bus.value_out), 32'h3002);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pg("al.win", 2, 1'b0);
        end
        step();
        chk_pg("al.exit", 1, 1'b1);
        chk("al.exit.value", 32'(bus.value_out), 32'h2001);

        // lower-index preemption restarts the window; higher index ignored
        bus.src_alert = 4'b0100;
        step();
        bus.src_alert = '0;
        chk_pg("pre.enter", 2, 1'b1);
        bus.src_alert = 4'b0001;
        step();
        bus.src_alert = 4'b1000;
        chk_pg("pre.take", 0, 1'b1);
        step();
        bus.src_alert = '0;
        chk_pg("pre.ignhi", 0, 1'b0);
        step();
        step();
        chk_pg("pre.last", 0, 1'b0);
        step();
        chk_pg("pre.exit", 1, 1'b1);

        // adv_tick aborts an alert without advancing
        bus.src_alert = 4'b0100;
        step();
        bus.src_alert = '0;
        chk_pg("abort.enter", 2, 1'b1);
        bus.adv_tick = 1'b1;
        step();
        bus.adv_tick = 1'b0;
        chk_pg("abort.exit", 1, 1'b1);

        // simultaneous adv_tick + alert: alert wins, no advance afterwards
        bus.adv_tick  = 1'b1;
        bus.src_alert = 4'b1000;
        step();
        bus.adv_tick  = 1'b0;
        bus.src_alert = '0;
        chk_pg("sim.enter", 3, 1'b1);
        step();
        step();
        step();
        chk_pg("sim.last", 3, 1'b0);
        step();
        chk_pg("sim.exit", 1, 1'b1);

        // saved page invalid at expiry -> next valid after it
        bus.src_alert = 4'b1000;
        step();
        bus.src_alert = '0;
        bus.src_valid = 4'b0001;
        step();
        step();
        step();
        chk_pg("sv.last", 3, 1'b0);
        step();
        chk_pg("sv.exit", 0, 1'b1);

        // alert from IDLE on an invalid source, expiring back to IDLE
        bus.src_valid = 4'b0000;
        step();
        chk("idle.blank", 32'(bus.blank), 32'd1);
        bus.src_alert = 4'b1000;
        step();
        bus.src_alert = '0;
        chk_pg("ialert", 3, 1'b1);
        chk("ialert.blank", 32'(bus.blank), 32'd0);
        chk("ialert.value", 32'(bus.value_out), 32'h4003);
        step();
        step();
        step();
        step();
        chk("ialert.end.blank", 32'(bus.blank), 32'd1);
        chk("ialert.end.value", 32'(bus.value_out), 32'd0);

        // clr mid-alert discards everything
        bus.src_alert = 4'b0010;
        step();
        bus.src_alert = '0;
        chk("clr.pre.blank", 32'(bus.blank), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_pg("clr", 0, 1'b0);
        chk("clr.blank", 32'(bus.blank), 32'd1);
        step();
        chk("clr.after.blank", 32'(bus.blank), 32'd1);

        bus.src_valid = 4'b0011;
        step();
        chk_pg("auto.start", 0, 1'b0);
`ifdef DISP_AUTOSCROLL_EN
        for (int i = 0; i < 7; i++) begin
            step();
            chk_pg("auto.p0", 0, 1'b0);
        end
        step();
        chk_pg("auto.to1", 1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_pg("auto.p1", 1, 1'b0);
        end
        step();
        chk_pg("auto.to0", 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        bus.adv_tick = 1'b1;
        step();
        bus.adv_tick = 1'b0;
        chk_pg("auto.adv", 1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_pg("auto.restart", 1, 1'b0);
        end
        step();
        chk_pg("auto.after", 0, 1'b1);
`else
        chg_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.page_chg) chg_cnt++;
        end
        chk("noauto.chg", 32'(chg_cnt), 32'd0);
        chk("noauto.page", 32'(bus.page), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/disp_page_ctrl.md
# disp_page_ctrl

Display page controller for the 4-digit seven-segment path. It arbitrates the single 16-bit display value between up to NSRC requesters, such as raw and debounced press counters or FIFO status. It rotates pages round-robin on a single-cycle advance tick, normally the edge-detected debounced button. It also grants short preemptive "alert" windows, and feeds a registered value, blanking and page marker to the display mux.

## Interface
- NSRC, 4: number of requesting sources (2..8).
- W, 16: width of each source value and of value_out.
- ALERT_CYCLES, 50_000_000: clock cycles an alert page is held (≥2).
- AUTO_CYCLES, 150_000_000: dwell period for auto-scroll (used only with DISP_AUTOSCROLL_EN).
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- adv_tick  in  1  single-cycle pulse requesting next page.
- src_data  in  NSRC*W  packed source values; source i at [i*W +: W].
- src_valid  in  NSRC  source i has displayable data (level).
- src_alert  in  NSRC  source i requests immediate display (pulse or level).
- value_out  out  W  registered value for the display mux.
- blank  out  1  display blank request.
- page  out  clog2(NSRC)  index of the source currently shown.
- page_chg  out  1  one-cycle pulse when page changes.

## Operation
- FSM with states IDLE, SHOW and ALERT; state encoding is free.
- IDLE
  - Condition: no src_valid bit set. Outputs: blank=1, value_out=0, page holds.
  - When any valid bit is set, go to SHOW on the lowest valid index.
- SHOW
  - value_out tracks src_data[page] live, registered each cycle; blank=0.
  - On adv_tick, page becomes the next valid index after page, searching upward and wrapping NSRC-1→0.
  - If page is the only valid source, adv_tick leaves page unchanged and there is no page_chg.
  - If src_valid[page] drops, advance to the next valid index the following cycle.
  - If no source is valid, go to IDLE.
- ALERT entry
  - Any src_alert bit in SHOW or IDLE goes to ALERT on the lowest-index alerting source, even if that source is invalid.
  - Current page is saved; the alert counter loads ALERT_CYCLES-1.
- ALERT
  - The alert source is shown and blank=0.
  - The counter decrements each cycle. At 0, return to the saved page, or to the next valid page if the saved page is no longer valid, or to IDLE if none is valid.
  - adv_tick during ALERT aborts the alert and returns to the saved page without advancing.
  - A new src_alert during ALERT from a lower index than the active one preempts it: the counter reloads and the saved page is unchanged. Equal or higher index alerts are ignored.
- Simultaneous events: in the same cycle, src_alert wins over adv_tick, and adv_tick wins over the auto-scroll expiry.
- page_chg pulses on every cycle in which page takes a new value, including alert entry and exit. It does not pulse on IDLE↔SHOW when the index is unchanged.

## Timing
- Reset values (clr high at an edge): state=IDLE, page=0, value_out=0, blank=1, page_chg=0, all counters 0, saved page 0.
- clr asserted mid-alert or mid-dwell discards all state on that edge.
- The first post-reset decision occurs at the first edge with clr low.
- Latency: an event sampled at edge n produces new page, value_out=src_data[new page], and page_chg=1 at edge n+1.
- A src_data change on the shown source appears on value_out one cycle later.
- Alert window: exactly ALERT_CYCLES cycles of alert page, counted from the first cycle page shows the alert source.

## Configuration
- Macro: DISP_AUTOSCROLL_EN.
- When defined:
  - A dwell counter runs in SHOW and restarts on every page change.
  - After AUTO_CYCLES cycles on one page, an internal advance equivalent to adv_tick is generated.
  - The counter is frozen in ALERT and IDLE, and cleared on return to SHOW.
- When undefined:
  - No dwell counter is built; AUTO_CYCLES is unused.
  - Pages change only by adv_tick, valid loss or alert.

## Test plan
- Reset/idle: clr=1 for 2 cycles with src_valid=0 → blank=1, value_out=0, page=0; set src_valid=4'b0100 → next cycle page=2, blank=0, page_chg=1.
- Round-robin with wrap: src_valid=4'b1011, page=0, three adv_tick pulses → page 1, 3, 0; each update is one cycle after its tick with a single page_chg pulse.
- Valid loss: on page 3, drop src_valid[3] → page=0 next cycle. Then drop all valid bits → IDLE, blank=1.
- Alert preemption (ALERT_CYCLES=4):
  - On page 1, pulse src_alert[2] → page=2 for exactly 4 cycles, then page=1.
  - Repeat with src_alert[0] mid-alert → page 0 for 4 fresh cycles, then page 1.
  - adv_tick during an alert → immediate return to page 1.
- Simultaneous: adv_tick and src_alert[3] in the same cycle → ALERT on page 3, no advance; after expiry return to the original page.
- DISP_AUTOSCROLL_EN (AUTO_CYCLES=8):
  - src_valid=4'b0011 → page toggles 0/1 every 8 cycles.
  - adv_tick at dwell cycle 5 → change plus dwell restart, so the next auto change comes 8 cycles later.
  - Without the macro: page stays constant for 100 cycles.
